dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters:
//   - port C: core Q4 load/store.
//   - port D: debug/DMA master.
//   Issues at most one access per cycle and routes read data back to the issuing port after a fixed RD_LAT.
//   Port C has priority. An anti-starvation counter guarantees port D a grant within MAX_WAIT contended cycles.
//   Sits between cpu_core's memory interface and the memory instance.
// PARAMETERS
//   AW        32  address width, both ports and memory side
//   RD_LAT    1   memory read latency in cycles (>=1); i_mem_rdata valid RD_LAT cycles after o_mem_en&!o_mem_we
//   MAX_WAIT  4   contended cycles port D may lose before it takes priority (>=1; 1 = alternate under contention)
// PORTS
//   i_clk        in   1   clock
//   i_rst        in   1   reset; one clock; reset is synchronous and active-high
//   i_c_req      in   1   port C access request; held with fields stable until o_c_gnt
//   i_c_we       in   1   port C write (1) / read (0)
//   i_c_addr     in   AW  port C byte address
//   i_c_wdata    in   32  port C write data
//   i_c_wstrb    in   4   port C byte enables (writes only)
//   o_c_gnt      out  1   port C request accepted and issued this cycle
//   o_c_rvalid   out  1   port C read data valid
//   o_c_rdata    out  32  port C read data
//   i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_wstrb, o_d_gnt, o_d_rvalid, o_d_rdata: same as port C, port D
//   o_mem_en     out  1   memory access strobe
//   o_mem_we     out  1   memory write enable
//   o_mem_addr   out  AW  memory address
//   o_mem_wdata  out  32  memory write data
//   o_mem_wstrb  out  4   memory byte enables
//   i_mem_rdata  in   32  memory read data
// BEHAVIOUR
//   - Priority state (1 FF): C_PRI (reset), D_PRI.
//     - C_PRI -> D_PRI when wait_cnt reaches MAX_WAIT.
//     - D_PRI -> C_PRI on o_d_gnt or !i_d_req.
//   - wait_cnt, $clog2(MAX_WAIT+1) bits, saturating:
//     - +1 in any cycle with i_d_req & !o_d_gnt.
//     - Cleared on o_d_gnt or !i_d_req.
//   - Grant logic is combinational, same cycle; exactly one winner when any request is present.
//     - C_PRI: C wins if i_c_req, else D.
//     - D_PRI: D wins if i_d_req, else C.
//     - o_c_gnt & o_d_gnt are never both 1.
//   - o_mem_en = o_c_gnt|o_d_gnt.
//     - o_mem_we/addr/wdata/wstrb are muxed from the winner.
//     - When idle: o_mem_we=0, wstrb=0, addr/wdata=0.
//   - Read return uses a tag pipe of RD_LAT stages {valid, port}.
//     - Stage 0 loads {o_mem_en&!o_mem_we, winner} each cycle.
//     - At the last stage: valid & port=C -> o_c_rvalid=1; port=D -> o_d_rvalid=1.
//     - o_x_rdata = i_mem_rdata when its rvalid is high, else 0.
//     - Writes never produce rvalid.
//   - Back-to-back issue is allowed every cycle. Responses return in issue order; no backpressure on rvalid.
//   - Reset, including mid-operation, clears:
//     - tag pipe, wait_cnt, state=C_PRI;
//     - all outputs to 0 (combinational outputs are 0 while i_rst is high; no grants during reset).
//     - In-flight reads are dropped and never signal rvalid.
//   - A request withdrawn before grant is a protocol error. The arbiter does not check it, but must not hang.
// TESTING
//   - Reset: hold i_rst 2 cycles with both req=1 -> no gnt, no mem_en, no rvalid; state=C_PRI, wait_cnt=0.
//   - Single read: C read addr 0x10, mem returns 0xDEADBEEF -> o_c_gnt same cycle; o_c_rvalid & o_c_rdata=0xDEADBEEF exactly RD_LAT cycles later; o_d_rvalid stays 0.
//   - Starvation: C and D request continuously, MAX_WAIT=4 -> grant pattern C,C,C,C,D repeating; D never waits >4 cycles.
//   - Interleaved reads (RD_LAT=2): C,D,C reads in consecutive cycles -> rvalid C,D,C in consecutive cycles, each with its own data.
//   - Write: D write 0x20 data 0x12345678 wstrb 4'b0011 -> o_mem_we=1 with those fields same cycle; no rvalid ever.
//   - Reset mid-flight: C read granted, i_rst asserted next cycle -> no o_c_rvalid; first post-reset request granted normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core port C has priority,
// debug/DMA port D is guaranteed a grant after MAX_WAIT lost contended cycles.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_c_req,
    input  logic          i_c_we,
    input  logic [AW-1:0] i_c_addr,
    input  logic [31:0]   i_c_wdata,
    input  logic [3:0]    i_c_wstrb,
    output logic          o_c_gnt,
    output logic          o_c_rvalid,
    output logic [31:0]   o_c_rdata,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [31:0]   i_d_wdata,
    input  logic [3:0]    i_d_wstrb,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [31:0]   o_d_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic [3:0]    o_mem_wstrb,
    input  logic [31:0]   i_mem_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic {C_PRI, D_PRI} pri_t;

    pri_t            state, state_nxt;
    logic [CW-1:0]   wait_cnt, wait_nxt;
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] port_pipe;   // 1 = read issued for port D
    logic            rvalid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= C_PRI;
            wait_cnt  <= '0;
            vld_pipe  <= '0;
            port_pipe <= '0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            vld_pipe[0]  <= o_mem_en & ~o_mem_we;
            port_pipe[0] <= o_d_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                port_pipe[i] <= port_pipe[i-1];
            end
        end
    end

    // Grants are suppressed entirely while reset is held.
    always_comb begin
        o_c_gnt = 1'b0;
        o_d_gnt = 1'b0;
        if (!i_rst) begin
            if (state == D_PRI) begin
                o_d_gnt = i_d_req;
                o_c_gnt = i_c_req & ~i_d_req;
            end else begin
                o_c_gnt = i_c_req;
                o_d_gnt = i_d_req & ~i_c_req;
            end
        end
    end

    always_comb begin
        wait_nxt  = wait_cnt;
        state_nxt = state;
        if (o_d_gnt || !i_d_req) begin
            wait_nxt  = '0;
            state_nxt = C_PRI;
        end else begin
            if (wait_cnt != WAIT_MAX)
                wait_nxt = wait_cnt + 1'b1;
            // Flip priority in the same cycle the count hits the limit, so D wins next cycle.
            if (wait_nxt == WAIT_MAX)
                state_nxt = D_PRI;
        end
    end

    always_comb begin
        o_mem_en    = o_c_gnt | o_d_gnt;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wstrb = '0;
        if (o_c_gnt) begin
            o_mem_we    = i_c_we;
            o_mem_addr  = i_c_addr;
            o_mem_wdata = i_c_wdata;
            o_mem_wstrb = i_c_wstrb;
        end else if (o_d_gnt) begin
            o_mem_we    = i_d_we;
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
            o_mem_wstrb = i_d_wstrb;
        end
    end

    // Gating with reset drops a response that would land in the reset cycle itself.
    assign rvalid     = vld_pipe[RD_LAT-1] & ~i_rst;
    assign o_c_rvalid = rvalid & ~port_pipe[RD_LAT-1];
    assign o_d_rvalid = rvalid & port_pipe[RD_LAT-1];
    assign o_c_rdata  = o_c_rvalid ? i_mem_rdata : '0;
    assign o_d_rdata  = o_d_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, every cycle checked
// against a loss-count / response-schedule model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;
    logic [3:0]  c_wstrb, d_wstrb;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    dmem_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .i_c_wstrb(c_wstrb), .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_wstrb(d_wstrb), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int losses = 0;              // consecutive cycles D requested and lost
    logic [1:0] sched [int];     // cycle -> 1 (C read returns) / 2 (D read returns)
    logic exp_c_gnt, exp_d_gnt;
    logic obs_c_gnt, obs_d_gnt, obs_mem_en, obs_mem_we, obs_c_rvalid, obs_d_rvalid;
    logic [31:0] obs_mem_addr, obs_mem_wdata, obs_c_rdata, obs_d_rdata;
    logic [3:0]  obs_mem_wstrb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: entered at posedge+1 with inputs set, leaves at next posedge+1.
    task automatic step();
        logic ec, ed, erc, erd, ewe;
        logic [31:0] eaddr, ewdata;
        logic [3:0] ewstrb;
        logic [1:0] port;
        ec = 1'b0; ed = 1'b0;
        if (!rst) begin
            ed = d_req && (!c_req || losses >= MAX_WAIT);
            ec = c_req && !ed;
        end
        ewe = ec ? c_we : (ed ? d_we : 1'b0);
        eaddr = ec ? c_addr : (ed ? d_addr : 32'h0);
        ewdata = ec ? c_wdata : (ed ? d_wdata : 32'h0);
        ewstrb = ec ? c_wstrb : (ed ? d_wstrb : 4'h0);
        port = sched.exists(cyc) ? sched[cyc] : 2'd0;
        erc = !rst && port == 2'd1;
        erd = !rst && port == 2'd2;
        @(negedge clk);
        obs_c_gnt = c_gnt; obs_d_gnt = d_gnt; obs_mem_en = mem_en; obs_mem_we = mem_we;
        obs_mem_addr = mem_addr; obs_mem_wdata = mem_wdata; obs_mem_wstrb = mem_wstrb;
        obs_c_rvalid = c_rvalid; obs_d_rvalid = d_rvalid;
        obs_c_rdata = c_rdata; obs_d_rdata = d_rdata;
        chk("c_gnt", 32'(c_gnt), 32'(ec));
        chk("d_gnt", 32'(d_gnt), 32'(ed));
        chk("mem_en", 32'(mem_en), 32'(ec | ed));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_addr", mem_addr, eaddr);
        chk("mem_wdata", mem_wdata, ewdata);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(ewstrb));
        chk("c_rvalid", 32'(c_rvalid), 32'(erc));
        chk("c_rdata", c_rdata, erc ? mem_rdata : 32'h0);
        chk("d_rvalid", 32'(d_rvalid), 32'(erd));
        chk("d_rdata", d_rdata, erd ? mem_rdata : 32'h0);
        exp_c_gnt = ec; exp_d_gnt = ed;
        if (rst) begin
            losses = 0;
            sched.delete();
        end else begin
            if (ed || !d_req) losses = 0;
            else if (losses < MAX_WAIT) losses++;
            if ((ec || ed) && !ewe) sched[cyc + RD_LAT] = ec ? 2'd1 : 2'd2;
            if (sched.exists(cyc)) sched.delete(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
        mem_rdata = $urandom;
    endtask

    task automatic c_read(input logic [31:0] a);
        c_req = 1'b1; c_we = 1'b0; c_addr = a; c_wdata = $urandom; c_wstrb = 4'hf;
    endtask

    task automatic d_read(input logic [31:0] a);
        d_req = 1'b1; d_we = 1'b0; d_addr = a; d_wdata = $urandom; d_wstrb = 4'hf;
    endtask

    task automatic idle(input int n);
        c_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; mem_rdata = 32'h0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_wstrb = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        @(posedge clk);
        #1;

        // Reset held two cycles with both ports requesting.
        c_read(32'h100); d_read(32'h200);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_quiet", {27'h0, obs_c_gnt, obs_d_gnt, obs_mem_en, obs_c_rvalid, obs_d_rvalid}, 32'h0);
        end
        rst = 1'b0;

        // Continuous contention: C,C,C,C,D repeating.
        for (int i = 0; i < 15; i++) begin
            step();
            chk("starve_d_gnt", 32'(obs_d_gnt), 32'(i % 5 == 4));
            chk("starve_c_gnt", 32'(obs_c_gnt), 32'(i % 5 != 4));
        end
        idle(RD_LAT + 1);

        // Single C read.
        c_read(32'h10);
        step();
        chk("rd_gnt", 32'(obs_c_gnt), 32'h1);
        chk("rd_addr", obs_mem_addr, 32'h10);
        c_req = 1'b0;
        step();
        chk("rd_early", 32'(obs_c_rvalid), 32'h0);
        mem_rdata = 32'hDEADBEEF;
        step();
        chk("rd_rvalid", 32'(obs_c_rvalid), 32'h1);
        chk("rd_rdata", obs_c_rdata, 32'hDEADBEEF);
        chk("rd_d_quiet", 32'(obs_d_rvalid), 32'h0);
        idle(2);

        // Interleaved C,D,C reads.
        c_read(32'h40); step();
        c_req = 1'b0; d_read(32'h44); step();
        d_req = 1'b0; c_read(32'h48); mem_rdata = 32'hA1A1A1A1; step();
        chk("il_c0", {obs_c_rvalid, obs_d_rvalid, obs_c_rdata[29:0]}, {2'b10, 30'h21A1A1A1});
        c_req = 1'b0; mem_rdata = 32'hB2B2B2B2; step();
        chk("il_d1", {obs_c_rvalid, obs_d_rvalid, obs_d_rdata[29:0]}, {2'b01, 30'h32B2B2B2});
        mem_rdata = 32'hC3C3C3C3; step();
        chk("il_c2", {obs_c_rvalid, obs_d_rvalid, obs_c_rdata[29:0]}, {2'b10, 30'h03C3C3C3});
        idle(2);

        // D write.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
        step();
        chk("wr_gnt", {30'h0, obs_d_gnt, obs_mem_we}, 32'h3);
        chk("wr_addr", obs_mem_addr, 32'h20);
        chk("wr_wdata", obs_mem_wdata, 32'h12345678);
        chk("wr_wstrb", 32'(obs_mem_wstrb), 32'h3);
        d_req = 1'b0;
        for (int i = 0; i < RD_LAT + 1; i++) begin
            step();
            chk("wr_no_rvalid", {30'h0, obs_c_rvalid, obs_d_rvalid}, 32'h0);
        end

        // Reset while a read is in flight.
        c_read(32'h80); step();
        chk("mf_gnt", 32'(obs_c_gnt), 32'h1);
        c_req = 1'b0; rst = 1'b1; step();
        chk("mf_drop0", 32'(obs_c_rvalid), 32'h0);
        rst = 1'b0; step();
        chk("mf_drop1", 32'(obs_c_rvalid), 32'h0);
        c_read(32'h84); step();
        chk("mf_post_gnt", 32'(obs_c_gnt), 32'h1);
        c_req = 1'b0; step(); step();
        chk("mf_post_rvalid", 32'(obs_c_rvalid), 32'h1);

        // Random traffic, requests held until granted.
        for (int n = 0; n < 500; n++) begin
            if (!c_req || exp_c_gnt) begin
                c_req = ($urandom % 4) != 0; c_we = $urandom % 2; c_addr = $urandom;
                c_wdata = $urandom; c_wstrb = 4'($urandom);
            end
            if (!d_req || exp_d_gnt) begin
                d_req = ($urandom % 4) != 0; d_we = $urandom % 2; d_addr = $urandom;
                d_wdata = $urandom; d_wstrb = 4'($urandom);
            end
            rst = ($urandom % 64) == 0;
            step();
        end
        rst = 1'b0;
        idle(RD_LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
